ras_controller: RTL

- Owns the return address stack (RAS) storage. Sequences speculative push/pop requests from the ID-stage hazard/forwarding control.
- Undoes speculative push/pop through per-stage rollback requests when the pipeline flushes.
- Holds the ra-track register used for mv/sw aliasing of ra.
- Sits beside the ID-stage control logic. Its top-of-stack feeds jalr target prediction.

---
 rtl/ras_controller_pkg.sv | 17 +
 rtl/ras_storage.sv | 26 ++
 rtl/ras_controller.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/ras_controller_pkg.sv
// Shared constants and types for the return address stack controller.
package ras_controller_pkg;

    // Architectural register indices used by the ra-track logic.
    localparam logic [4:0] REG_RA = 5'd1;

    // Default number of RAS entries.
    localparam int unsigned RAS_DEPTH = 8;

    // Record of the push made by the instruction now one stage past ID.
    typedef struct packed {
        logic valid;     // a push was performed
        logic replaced;  // it was a push+pop replacement of the top entry
        logic was_full;  // the push evicted the oldest entry
    } push_shadow_t;

endpackage

// File: rtl/ras_storage.sv
// Circular return address array: one write port, combinational read at tos.
module ras_storage #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 32,
    localparam int unsigned PW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [PW-1:0] waddr,
    input  logic [AW-1:0] wdata,
    input  logic [PW-1:0] raddr,
    output logic [AW-1:0] rdata
);

    logic [AW-1:0] mem [DEPTH];

    // Contents are not reset; validity is tracked by the controller's count.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ras_controller.sv
// Return address stack controller: speculative push/pop, rollback of
// flushed push/pop through a two-stage shadow pipe, and the ra-track register.
module ras_controller
    import ras_controller_pkg::*;
#(
    parameter int unsigned DEPTH = RAS_DEPTH,
    parameter int unsigned AW    = 32,
    localparam int unsigned PW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          PL_stall,
    input  logic          RAS_push,
    input  logic [AW-1:0] RAS_push_addr,
    input  logic          RAS_pop,
    input  logic          RAS_rollback_pop_id,
    input  logic          RAS_rollback_push_id,
    input  logic          RAS_rollback_push_ex,
    input  logic          WR_ra_track_en,
    input  logic [4:0]    WR_ra_track_data,
    output logic [AW-1:0] RAS_top,
    output logic          RAS_top_valid,
    output logic [4:0]    RAS_ra_track,
    output logic [PW:0]   RAS_count
);

    typedef struct packed {
        logic          valid;
        logic [AW-1:0] addr;
    } pop_shadow_t;

    localparam logic [PW:0] CountMax = DEPTH[PW:0];

    logic [PW-1:0] tos_q, tos_d;
    logic [PW:0]   count_q, count_d;
    logic [4:0]    ra_track_q, ra_track_d;
    pop_shadow_t   pop_sh_id_q, pop_sh_id_d;
    pop_shadow_t   pop_sh_ex_q, pop_sh_ex_d;
    push_shadow_t  push_sh_id_q, push_sh_id_d;

    logic          we;
    logic [AW-1:0] wdata;
    logic [AW-1:0] top_rdata;
    logic          rollback;
    logic          do_push;
    logic          do_pop;
    logic          nonempty;
    logic          pop_id_used;

    assign rollback = RAS_rollback_pop_id | RAS_rollback_push_id | RAS_rollback_push_ex;
    assign do_push  = RAS_push & ~rollback;
    assign do_pop   = RAS_pop & ~rollback;
    assign nonempty = (count_q != '0);

    ras_storage #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_storage (
        .clk   (clk),
        .we    (we),
        .waddr (tos_d),
        .wdata (wdata),
        .raddr (tos_q),
        .rdata (top_rdata)
    );

    // Next tos/count and the single array write. Rollback steps run youngest
    // first; each write lands at the running tos, so the last write is always
    // the final top entry. Entries below it are relied on to still hold their
    // popped values.
    always_comb begin
        tos_d       = tos_q;
        count_d     = count_q;
        we          = 1'b0;
        wdata       = RAS_push_addr;
        pop_id_used = 1'b0;
        if (rollback) begin
            if (RAS_rollback_pop_id && push_sh_id_q.valid) begin
                if (push_sh_id_q.replaced) begin
                    // Undoing a replacement also undoes its pop, so the ID pop
                    // shadow is consumed here and not replayed below.
                    if (pop_sh_id_q.valid) begin
                        we          = 1'b1;
                        wdata       = pop_sh_id_q.addr;
                        pop_id_used = 1'b1;
                    end else if (count_d != '0) begin
                        count_d = count_d - 1'b1;
                    end
                end else begin
                    tos_d = tos_d - 1'b1;
                    if (push_sh_id_q.was_full) begin
                        count_d = CountMax - 1'b1;
                    end else if (count_d != '0) begin
                        count_d = count_d - 1'b1;
                    end
                end
            end
            if (RAS_rollback_push_id && pop_sh_id_q.valid && !pop_id_used) begin
                tos_d = tos_d + 1'b1;
                we    = 1'b1;
                wdata = pop_sh_id_q.addr;
                if (count_d != CountMax) begin
                    count_d = count_d + 1'b1;
                end
            end
            if (RAS_rollback_push_ex && pop_sh_ex_q.valid) begin
                tos_d = tos_d + 1'b1;
                we    = 1'b1;
                wdata = pop_sh_ex_q.addr;
                if (count_d != CountMax) begin
                    count_d = count_d + 1'b1;
                end
            end
        end else if (do_push && do_pop) begin
            we = 1'b1;
            if (!nonempty) begin
                count_d = {{PW{1'b0}}, 1'b1};
            end
        end else if (do_push) begin
            tos_d = tos_q + 1'b1;
            we    = 1'b1;
            if (count_q != CountMax) begin
                count_d = count_q + 1'b1;
            end
        end else if (do_pop && nonempty) begin
            tos_d   = tos_q - 1'b1;
            count_d = count_q - 1'b1;
        end
    end

    // Shadow pipe: clears on any rollback, otherwise advances unless stalled.
    always_comb begin
        pop_sh_id_d  = pop_sh_id_q;
        pop_sh_ex_d  = pop_sh_ex_q;
        push_sh_id_d = push_sh_id_q;
        if (rollback) begin
            pop_sh_id_d  = '0;
            pop_sh_ex_d  = '0;
            push_sh_id_d = '0;
        end else if (!PL_stall) begin
            pop_sh_id_d.valid     = do_pop & nonempty;
            pop_sh_id_d.addr      = top_rdata;
            pop_sh_ex_d           = pop_sh_id_q;
            push_sh_id_d.valid    = do_push;
            push_sh_id_d.replaced = do_push & do_pop;
            push_sh_id_d.was_full = do_push & ~do_pop & (count_q == CountMax);
        end
    end

    // ra-track: an explicit write wins over the clear caused by a push.
    always_comb begin
        ra_track_d = ra_track_q;
        if (WR_ra_track_en) begin
            ra_track_d = WR_ra_track_data;
        end else if (do_push) begin
            ra_track_d = REG_RA;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tos_q        <= '0;
            count_q      <= '0;
            ra_track_q   <= REG_RA;
            pop_sh_id_q  <= '0;
            pop_sh_ex_q  <= '0;
            push_sh_id_q <= '0;
        end else begin
            tos_q        <= tos_d;
            count_q      <= count_d;
            ra_track_q   <= ra_track_d;
            pop_sh_id_q  <= pop_sh_id_d;
            pop_sh_ex_q  <= pop_sh_ex_d;
            push_sh_id_q <= push_sh_id_d;
        end
    end

    assign RAS_top       = nonempty ? top_rdata : '0;
    assign RAS_top_valid = nonempty;
    assign RAS_ra_track  = ra_track_q;
    assign RAS_count     = count_q;

endmodule
